// File: rtl/morse_code_transmit.sv
// Morse transmitter: accepts one ASCII byte per valid/ready handshake, encodes it
// to {len, pattern} and keys it out on key_out with standard dot/dash/gap timing.
module morse_code_transmit #(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic       etx_out
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  // Returns {supported, len[2:0], pattern[4:0]}; first symbol is pattern[len-1].
  function automatic logic [8:0] encode(input logic [7:0] ch);
    logic [7:0] u;
    u = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    case (u)
      8'h41: encode = {1'b1, 8'b010_00001};
      8'h42: encode = {1'b1, 8'b100_01000};
      8'h43: encode = {1'b1, 8'b100_01010};
      8'h44: encode = {1'b1, 8'b011_00100};
      8'h45: encode = {1'b1, 8'b001_00000};
      8'h46: encode = {1'b1, 8'b100_00010};
      8'h47: encode = {1'b1, 8'b011_00110};
      8'h48: encode = {1'b1, 8'b100_00000};
      8'h49: encode = {1'b1, 8'b010_00000};
      8'h4A: encode = {1'b1, 8'b100_00111};
      8'h4B: encode = {1'b1, 8'b011_00101};
      8'h4C: encode = {1'b1, 8'b100_00100};
      8'h4D: encode = {1'b1, 8'b010_00011};
      8'h4E: encode = {1'b1, 8'b010_00010};
      8'h4F: encode = {1'b1, 8'b011_00111};
      8'h50: encode = {1'b1, 8'b100_00110};
      8'h51: encode = {1'b1, 8'b100_01101};
      8'h52: encode = {1'b1, 8'b011_00010};
      8'h53: encode = {1'b1, 8'b011_00000};
      8'h54: encode = {1'b1, 8'b001_00001};
      8'h55: encode = {1'b1, 8'b011_00001};
      8'h56: encode = {1'b1, 8'b100_00001};
      8'h57: encode = {1'b1, 8'b011_00011};
      8'h58: encode = {1'b1, 8'b100_01001};
      8'h59: encode = {1'b1, 8'b100_01011};
      8'h5A: encode = {1'b1, 8'b100_01100};
      8'h30: encode = {1'b1, 8'b101_11111};
      8'h31: encode = {1'b1, 8'b101_01111};
      8'h32: encode = {1'b1, 8'b101_00111};
      8'h33: encode = {1'b1, 8'b101_00011};
      8'h34: encode = {1'b1, 8'b101_00001};
      8'h35: encode = {1'b1, 8'b101_00000};
      8'h36: encode = {1'b1, 8'b101_10000};
      8'h37: encode = {1'b1, 8'b101_11000};
      8'h38: encode = {1'b1, 8'b101_11100};
      8'h39: encode = {1'b1, 8'b101_11110};
      8'h20: encode = {1'b1, 8'b110_00000};
      8'h03: encode = {1'b1, 8'b111_00000};
      default: encode = '0;
    endcase
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    units, units_n;
  logic [2:0]    idx, idx_n;
  logic [4:0]    pattern, pattern_n;
  logic [2:0]    target, target_n;
  logic          etx_n, key_n;
  logic [8:0]    code;
  logic          tick;
  logic [2:0]    mark_target;

  assign code        = encode(in_data);
  assign tick        = (cnt == CNT_MAX);
  assign mark_target = pattern[idx] ? 3'd3 : 3'd1;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = tick ? '0 : cnt + CW'(1);
    units_n   = tick ? units + 3'd1 : units;
    idx_n     = idx;
    pattern_n = pattern;
    target_n  = target;
    etx_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        units_n = '0;
        if (in_valid && code[8]) begin
          case (code[7:5])
            3'd7: etx_n = 1'b1;
            3'd6: begin
              state_n  = GAP;
              target_n = 3'd4;
            end
            default: begin
              state_n   = MARK;
              idx_n     = code[7:5] - 3'd1;
              pattern_n = code[4:0];
            end
          endcase
        end
      end
      MARK: begin
        if (tick && (units + 3'd1 == mark_target)) begin
          units_n = '0;
          if (idx == 3'd0) begin
            state_n  = GAP;
            target_n = 3'd3;
          end else begin
            state_n = SPACE;
            idx_n   = idx - 3'd1;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          units_n = '0;
          state_n = MARK;
        end
      end
      GAP: begin
        if (tick && (units + 3'd1 == target)) begin
          units_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    key_n = (state_n == MARK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      units   <= '0;
      idx     <= '0;
      pattern <= '0;
      target  <= '0;
      key_out <= 1'b0;
      etx_out <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      units   <= units_n;
      idx     <= idx_n;
      pattern <= pattern_n;
      target  <= target_n;
      key_out <= key_n;
      etx_out <= etx_n;
    end
  end

endmodule

// File: tb/tb_morse_code_transmit.sv
// Bench for morse_code_transmit at UNIT_CYCLES=4: table of per-character timing
// totals, hand sequences for multi-cycle corners, and randomized traffic vs a model.
module tb_morse_code_transmit;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       etx_out;

  int total = 0;
  int bad   = 0;
  int last_busy, last_high, last_wait;
  bit noise = 1'b0;
  bit exp_q[$];

  typedef struct {
    logic [7:0] c;
    int         busy_cycles;
    int         high_cycles;
  } vec_t;
  vec_t vecs[9];

  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                     ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                     "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                     "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                     "--...", "---..", "----."};

  morse_code_transmit #(.UNIT_CYCLES(U)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
    .etx_out  (etx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected key_out per cycle after acceptance, from the dot/dash strings.
  function automatic void build(input logic [7:0] c);
    string s;
    logic [7:0] u;
    exp_q.delete();
    u = c;
    if (c == 8'h20) begin
      repeat (4 * U) exp_q.push_back(1'b0);
      return;
    end
    if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
    if (u >= 8'h41 && u <= 8'h5A) s = tbl[u - 8'h41];
    else if (u >= 8'h30 && u <= 8'h39) s = tbl[26 + int'(u - 8'h30)];
    else s = "";
    for (int j = 0; j < s.len(); j++) begin
      repeat ((s[j] == 8'h2D ? 3 : 1) * U) exp_q.push_back(1'b1);
      if (j < s.len() - 1) repeat (U) exp_q.push_back(1'b0);
    end
    if (s.len() > 0) repeat (3 * U) exp_q.push_back(1'b0);
  endfunction

  // Called at a negedge; offers c as soon as in_ready, then checks every cycle.
  task automatic run_char(input logic [7:0] c);
    int n;
    logic kexp;
    last_wait = 0;
    last_busy = 0;
    last_high = 0;
    while (!in_ready && last_wait < 300) begin
      @(negedge clk);
      last_wait++;
    end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
      return;
    end
    build(c);
    n = exp_q.size();
    in_data  = c;
    in_valid = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (noise && i < n) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      kexp = (i < n) ? exp_q[i] : 1'b0;
      chk("key_out", key_out, kexp);
      chk("busy", busy, (i < n));
      chk("in_ready", in_ready, (i >= n));
      chk("etx_out", etx_out, (i == 0 && c == 8'h03));
      if (busy) last_busy++;
      if (key_out) last_high++;
    end
  endtask

  initial begin
    int low_e, low_s;
    string pool;
    logic [7:0] c;

    vecs[0] = '{8'h45, 16, 4};
    vecs[1] = '{8'h41, 32, 16};
    vecs[2] = '{8'h61, 32, 16};
    vecs[3] = '{8'h30, 88, 60};
    vecs[4] = '{8'h35, 48, 20};
    vecs[5] = '{8'h20, 16, 0};
    vecs[6] = '{8'h03, 0, 0};
    vecs[7] = '{8'h23, 0, 0};
    vecs[8] = '{8'h7A, 56, 32};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_etx", etx_out, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      run_char(vecs[v].c);
      chk("tbl_busy_len", last_busy, vecs[v].busy_cycles);
      chk("tbl_high_len", last_high, vecs[v].high_cycles);
    end

    // Back-to-back: second char must be taken on the first ready cycle
    run_char(8'h41);
    run_char(8'h61);
    chk("b2b_wait", last_wait, 0);
    chk("b2b_busy", last_busy, 32);
    chk("b2b_high", last_high, 16);

    // Word gap: E, space, T gives 12 + 16 low cycles between marks
    run_char(8'h45);
    low_e = last_busy - last_high;
    run_char(8'h20);
    low_s = last_busy;
    run_char(8'h54);
    chk("word_gap", low_e + low_s, 28);
    chk("word_t_high", last_high, 12);

    // ETX pulse lasts a single cycle
    run_char(8'h03);
    @(negedge clk);
    chk("etx_one_cycle", etx_out, 0);
    chk("etx_ready", in_ready, 1);

    // Reset five cycles into a dash
    in_data  = 8'h54;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_key", key_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_key", key_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_key", key_out, 0);
    run_char(8'h45);
    chk("post_rst_e_busy", last_busy, 16);
    chk("post_rst_e_high", last_high, 4);

    // Randomized traffic with junk offered while busy
    noise = 1'b1;
    pool  = "ABCQXYZabcqrs0123456789 E#";
    repeat (40) begin
      if ($urandom_range(0, 3) != 0)
        c = pool[$urandom_range(0, pool.len() - 1)];
      else
        c = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_char(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
